// File: rtl/periph_ctrl.sv
// periph_ctrl -- memory-mapped peripheral block on the CPU data bus.
//
// Claims every access whose addr[31:28] equals PERIPH_NIB. It holds a reload
// timer with an interrupt, plus LED, switch and 7-segment digit registers.
// Only addr[4:2] selects the register, so addr[27:5] aliases across the
// window and addr[1:0] is ignored.
//
//   offset 0  TH       RW 32      timer reload value
//   offset 1  TL       RW 32      timer count
//   offset 2  TCON     RW 3       [0] run, [1] irq enable, [2] irq status
//   offset 3  LED      RW LED_W
//   offset 4  SW       RO SW_W    writes ignored
//   offset 5  DIGI     RW DIGI_W  {an[3:0], seg[7:0]}
//   offset 6  SYSTICK  RO 32      free-running counter, only with PERIPH_SYSTICK_EN
//   offset 7  unmapped            reads 0
//
// Build option: define PERIPH_SYSTICK_EN to add the SYSTICK counter. Without
// it, offset 6 reads 0 in the same way as offset 7.
//
// Ports:
//   clk     in   1       system clock; all state updates on posedge
//   reset   in   1       asynchronous, active-high reset
//   rd      in   1       read strobe
//   wr      in   1       write strobe
//   addr    in   32      byte address
//   wdata   in   32      write data
//   rdata   out  32      combinational read data; 0 unless rd is high and the block is selected
//   switch  in   SW_W    board switches, sampled combinationally on read
//   led     out  LED_W   LED register
//   digi    out  DIGI_W  7-segment register
//   irqout  out  1       timer interrupt request (TCON[2]), level
module periph_ctrl #(
    parameter logic [3:0]  PERIPH_NIB = 4'h4,
    parameter int unsigned LED_W      = 8,
    parameter int unsigned SW_W       = 8,
    parameter int unsigned DIGI_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led,
    output logic [DIGI_W-1:0] digi,
    output logic              irqout
);

    logic [31:0]       r_th;
    logic [31:0]       r_tl;
    logic [2:0]        r_tcon;
    logic [LED_W-1:0]  r_led;
    logic [DIGI_W-1:0] r_digi;
`ifdef PERIPH_SYSTICK_EN
    logic [31:0]       r_systick;
`endif

    logic        w_sel;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_wr_led;
    logic        w_wr_digi;
    logic        w_tl_max;
    logic        w_irq_set;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel     = (addr[31:28] == PERIPH_NIB);
    assign w_off     = addr[4:2];
    assign w_wr      = wr && w_sel;
    assign w_wr_th   = w_wr && (w_off == 3'd0);
    assign w_wr_tl   = w_wr && (w_off == 3'd1);
    assign w_wr_tcon = w_wr && (w_off == 3'd2);
    assign w_wr_led  = w_wr && (w_off == 3'd3);
    assign w_wr_digi = w_wr && (w_off == 3'd5);

    assign w_tl_max  = (r_tl == 32'hFFFF_FFFF);
    // A CPU write to TL pre-empts the reload on the same edge, so that edge
    // cannot raise the interrupt either.
    assign w_irq_set = r_tcon[0] && r_tcon[1] && w_tl_max && !w_wr_tl;

    // Address bits outside the decode and high write-data bits are deliberately ignored.
    assign w_unused  = ^{addr[27:5], addr[1:0], wdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th   <= '0;
            r_tl   <= '0;
            r_tcon <= '0;
            r_led  <= '0;
            r_digi <= '0;
        end else begin
            // The reload reads r_th before this edge, so a same-edge TH write
            // only affects the next reload.
            if (w_wr_th) begin
                r_th <= wdata;
            end

            if (w_wr_tl) begin
                r_tl <= wdata;
            end else if (r_tcon[0]) begin
                r_tl <= w_tl_max ? r_th : r_tl + 32'd1;
            end

            // A hardware interrupt on the same edge as a TCON write is OR-ed
            // into the status bit, so the interrupt is never lost.
            if (w_wr_tcon) begin
                r_tcon <= {wdata[2] | w_irq_set, wdata[1:0]};
            end else if (w_irq_set) begin
                r_tcon[2] <= 1'b1;
            end

            if (w_wr_led) begin
                r_led <= wdata[LED_W-1:0];
            end

            if (w_wr_digi) begin
                r_digi <= wdata[DIGI_W-1:0];
            end
        end
    end

`ifdef PERIPH_SYSTICK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_systick <= '0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (rd && w_sel) begin
            case (w_off)
                3'd0:    w_rdata = r_th;
                3'd1:    w_rdata = r_tl;
                3'd2:    w_rdata = 32'(r_tcon);
                3'd3:    w_rdata = 32'(r_led);
                3'd4:    w_rdata = 32'(switch);
                3'd5:    w_rdata = 32'(r_digi);
`ifdef PERIPH_SYSTICK_EN
                3'd6:    w_rdata = r_systick;
`endif
                default: w_rdata = '0;
            endcase
        end
    end

    assign rdata  = w_rdata;
    assign led    = r_led;
    assign digi   = r_digi;
    assign irqout = r_tcon[2];

endmodule

// File: tb/tb_periph_ctrl.sv
// Directed testbench for periph_ctrl.
module tb_periph_ctrl;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_TICK = 32'h4000_0018;
    localparam logic [31:0] A_UNM  = 32'h4000_001C;

    logic        clk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;

    int unsigned n_tests;
    int unsigned n_fail;

    periph_ctrl #(
        .PERIPH_NIB (4'h4),
        .LED_W      (8),
        .SW_W       (8),
        .DIGI_W     (12)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .switch (switch),
        .led    (led),
        .digi   (digi),
        .irqout (irqout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One write cycle: inputs driven at the negedge, captured at the next posedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr    = 1'b0;
        wdata = '0;
    endtask

    // Combinational read, kept away from clock edges by the callers.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd   = 1'b1;
        addr = a;
        #1;
        d    = rdata;
        rd   = 1'b0;
    endtask

    logic [31:0] d;
    logic [31:0] t0;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        wdata   = '0;
        switch  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        bus_read(A_TL, d);   check("rst_tl", d, 32'h0);
        bus_read(A_TCON, d); check("rst_tcon", d, 32'h0);
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_irq", {31'h0, irqout}, 32'h0);

        // 1: asynchronous reset while the timer is running with the irq set
        bus_write(A_LED, 32'h0000_0033);
        bus_write(A_DIGI, 32'h0000_0123);
        bus_write(A_TL, 32'h0000_0005);
        bus_write(A_TCON, 32'h0000_0007);
        bus_read(A_TL, d);   check("t1_pre_tl", d, 32'h5);
        check("t1_pre_irq", {31'h0, irqout}, 32'h1);
        reset = 1'b1;
        #1;
        bus_read(A_TL, d);   check("t1_tl", d, 32'h0);
        bus_read(A_TCON, d); check("t1_tcon", d, 32'h0);
        check("t1_led", {24'h0, led}, 32'h0);
        check("t1_digi", {20'h0, digi}, 32'h0);
        check("t1_irq", {31'h0, irqout}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 2: count up to the top, then reload from TH and raise the irq
        bus_write(A_TH, 32'hFFFF_FFFC);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h0000_0003);
        bus_read(A_TL, d);   check("t2_tl0", d, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        bus_read(A_TL, d);   check("t2_tl1", d, 32'hFFFF_FFFF);
        check("t2_irq0", {31'h0, irqout}, 32'h0);
        @(posedge clk); #1;
        bus_read(A_TL, d);   check("t2_reload", d, 32'hFFFF_FFFC);
        bus_read(A_TCON, d); check("t2_tcon", d, 32'h7);
        check("t2_irq1", {31'h0, irqout}, 32'h1);

        // 3: a TCON write on the irq-set edge keeps the irq; a later one clears it
        bus_write(A_TCON, 32'h0000_0000);
        bus_write(A_TL, 32'hFFFF_FFFE);
        check("t3_irq_clr", {31'h0, irqout}, 32'h0);
        bus_write(A_TCON, 32'h0000_0003);
        @(posedge clk); #1;
        bus_read(A_TL, d);   check("t3_tl_max", d, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'h0000_0003);
        bus_read(A_TCON, d); check("t3_tcon_kept", d, 32'h7);
        bus_read(A_TL, d);   check("t3_tl_reload", d, 32'hFFFF_FFFC);
        bus_write(A_TCON, 32'h0000_0003);
        bus_read(A_TCON, d); check("t3_tcon_clr", d, 32'h3);
        check("t3_irq", {31'h0, irqout}, 32'h0);
        bus_write(A_TCON, 32'h0000_0000);

        // A TL write wins over the increment on the same edge
        bus_write(A_TL, 32'h0000_0100);
        bus_write(A_TCON, 32'h0000_0001);
        bus_write(A_TL, 32'h0000_0200);
        bus_write(A_TCON, 32'h0000_0000);
        bus_read(A_TL, d);   check("tl_wr_wins", d, 32'h0000_0201);

        // 4: LED, DIGI and switch registers
        bus_write(A_LED, 32'h0000_00A5);
        bus_write(A_DIGI, 32'h0000_03F7);
        switch = 8'h5A;
        check("t4_led", {24'h0, led}, 32'h0000_00A5);
        check("t4_digi", {20'h0, digi}, 32'h0000_03F7);
        bus_read(A_SW, d);   check("t4_sw", d, 32'h0000_005A);
        bus_read(A_LED, d);  check("t4_led_rd", d, 32'h0000_00A5);
        bus_read(A_DIGI, d); check("t4_digi_rd", d, 32'h0000_03F7);

        // 5: unmapped reads, reads without rd, ignored writes, aliases
        bus_read(32'h1000_000C, d); check("t5_unsel", d, 32'h0);
        bus_read(A_UNM, d);         check("t5_unm", d, 32'h0);
        rd = 1'b0; addr = A_LED; #1;
        check("t5_no_rd", rdata, 32'h0);
        bus_write(A_SW, 32'h0000_00FF);
        bus_write(A_UNM, 32'hFFFF_FFFF);
        bus_write(32'h3000_000C, 32'h0000_0011);
        check("t5_led_kept", {24'h0, led}, 32'h0000_00A5);
        check("t5_digi_kept", {20'h0, digi}, 32'h0000_03F7);
        bus_read(A_SW, d);          check("t5_sw_kept", d, 32'h0000_005A);
        bus_write(32'h4FFF_FFEC, 32'h0000_003C);
        check("t5_alias_led", {24'h0, led}, 32'h0000_003C);

        // rd and wr together: rdata shows the pre-edge value
        bus_read(A_TH, d);   check("rw_th_old", d, 32'hFFFF_FFFC);
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = A_TH; wdata = 32'h1234_5678;
        #1;
        check("rw_pre", rdata, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        wr = 1'b0;
        check("rw_post", rdata, 32'h1234_5678);
        rd = 1'b0;

        // 6: SYSTICK
`ifdef PERIPH_SYSTICK_EN
        @(posedge clk); #1;
        bus_read(A_TICK, t0);
        repeat (10) @(posedge clk);
        #1;
        bus_read(A_TICK, d);
        check("t6_tick_delta", d - t0, 32'd10);
`else
        bus_read(A_TICK, d); check("t6_tick_off", d, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
